// File: rtl/scramble_sequencer.sv
// scramble_sequencer
//   Sequences the puzzle's shuffle-then-solve flow. In mix mode a scramble
//   button press issues RAND_NUM pseudo-random moves to the move datapath
//   over a valid/ack handshake, then the block waits in solve mode until the
//   datapath reports a solved board and sounds the buzzer for BUZZ_CYCLES.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous active-high reset
//   mix_state       1 = user selected mix mode
//   scramble_button debounced, level-sensitive scramble request
//   solved          datapath reports the board is solved
//   move_ack        datapath accepts the presented move this cycle
//   move_valid      a move is presented on move_code
//   move_code       00 up, 01 down, 10 left, 11 right
//   move_count      moves accepted in the current scramble
//   busy            1 while scrambling
//   solve_mode      1 while waiting for the solve
//   no_buzz         0 = buzzer on, 1 = silent
module scramble_sequencer #(
  parameter int          RAND_NUM    = 31,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          BUZZ_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mix_state,
  input  logic       scramble_button,
  input  logic       solved,
  input  logic       move_ack,
  output logic       move_valid,
  output logic [1:0] move_code,
  output logic [7:0] move_count,
  output logic       busy,
  output logic       solve_mode,
  output logic       no_buzz
);

  // An all-zero seed would lock the LFSR, so fall back to a known-good one.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [7:0]  RN   = 8'(RAND_NUM);
  localparam int          BW   = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
  localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ARMED, SCRAMBLE, SOLVE, DONE} state_t;

  state_t        state, state_nx;
  logic [15:0]   lfsr;
  logic          lfsr_fb;
  logic          btn_q;
  logic          press;
  logic          start;
  logic [BW-1:0] buzz_cnt, buzz_nx;
  logic          valid_nx;
  logic [1:0]    code_nx;
  logic [7:0]    count_nx;
  logic [7:0]    count_inc;

  // Fibonacci taps 16,14,13,11. Free-running, so the captured moves depend
  // on when the user presses the button.
  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  // Rising edge only: a held button yields a single press.
  assign press     = scramble_button & ~btn_q;
  assign count_inc = move_count + 8'd1;

  always_comb begin
    state_nx = state;
    valid_nx = move_valid;
    code_nx  = move_code;
    count_nx = move_count;
    buzz_nx  = buzz_cnt;
    start    = 1'b0;
    case (state)
      IDLE: begin
        if (mix_state) state_nx = ARMED;
      end
      ARMED: begin
        if (!mix_state)  state_nx = IDLE;
        else if (press)  start    = 1'b1;
      end
      SCRAMBLE: begin
        // Other inputs are ignored here: a scramble always runs to the end.
        if (move_valid && move_ack) begin
          count_nx = count_inc;
          if (count_inc < RN) begin
            code_nx = lfsr[1:0];
          end else begin
            valid_nx = 1'b0;
            state_nx = SOLVE;
          end
        end
      end
      SOLVE: begin
        if (solved) begin
          state_nx = DONE;
          buzz_nx  = '0;
        end else if (press && mix_state) begin
          start = 1'b1;
        end else if (!mix_state) begin
          state_nx = IDLE;
        end
      end
      DONE: begin
        if (buzz_cnt == BUZZ_LAST) state_nx = IDLE;
        else                       buzz_nx  = buzz_cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    // Scramble entry: first move is presented on the entry edge.
    if (start) begin
      state_nx = SCRAMBLE;
      valid_nx = 1'b1;
      code_nx  = lfsr[1:0];
      count_nx = 8'd0;
    end
  end

  // Status outputs are decoded from the next state so they change on the
  // same edge as the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lfsr       <= SEED;
      btn_q      <= 1'b0;
      buzz_cnt   <= '0;
      move_valid <= 1'b0;
      move_code  <= 2'b00;
      move_count <= 8'd0;
      busy       <= 1'b0;
      solve_mode <= 1'b0;
      no_buzz    <= 1'b1;
    end else begin
      state      <= state_nx;
      lfsr       <= {lfsr[14:0], lfsr_fb};
      btn_q      <= scramble_button;
      buzz_cnt   <= buzz_nx;
      move_valid <= valid_nx;
      move_code  <= code_nx;
      move_count <= count_nx;
      busy       <= (state_nx == SCRAMBLE);
      solve_mode <= (state_nx == SOLVE);
      no_buzz    <= (state_nx != DONE);
    end
  end

endmodule

// File: tb/tb_scramble_sequencer.sv
// Testbench for scramble_sequencer. A reference model of the sequencer is
// stepped once per clock; predicted move codes go into a scoreboard queue
// when the model captures them and are popped when the DUT's move is acked.
module tb_scramble_sequencer;

  localparam int          RAND_NUM = 31;
  localparam int          BUZZ     = 1000;
  localparam logic [15:0] SEED     = 16'hACE1;

  localparam int S_IDLE = 0, S_ARMED = 1, S_SCR = 2, S_SOLVE = 3, S_DONE = 4;

  logic       clk = 1'b0;
  logic       reset, mix_state, scramble_button, solved, move_ack;
  logic       move_valid, busy, solve_mode, no_buzz;
  logic [1:0] move_code;
  logic [7:0] move_count;

  always #5 clk = ~clk;

  scramble_sequencer #(.RAND_NUM(RAND_NUM), .LFSR_SEED(SEED), .BUZZ_CYCLES(BUZZ)) dut (
    .clk(clk), .reset(reset), .mix_state(mix_state), .scramble_button(scramble_button),
    .solved(solved), .move_ack(move_ack), .move_valid(move_valid), .move_code(move_code),
    .move_count(move_count), .busy(busy), .solve_mode(solve_mode), .no_buzz(no_buzz)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [1:0]  q[$];

  int          m_st, m_cnt, m_buzz;
  logic [15:0] m_lfsr;
  logic        m_btnq, m_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_nx(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_cnt = 0; m_buzz = 0;
    m_lfsr = SEED; m_btnq = 1'b0; m_valid = 1'b0;
    q.delete();
  endtask

  // One clock: check presented code, advance the model, clock the DUT,
  // then compare all status outputs with the model.
  task automatic tick();
    logic press, start;
    if (move_valid) begin
      if (q.size() == 0) chk("code_queue_empty", 32'd1, 32'd0);
      else               chk("move_code", move_code, q[0]);
    end
    press = scramble_button & ~m_btnq;
    start = 1'b0;
    case (m_st)
      S_IDLE:  if (mix_state) m_st = S_ARMED;
      S_ARMED: if (!mix_state) m_st = S_IDLE; else if (press) start = 1'b1;
      S_SCR: if (m_valid && move_ack) begin
        if (q.size() > 0) void'(q.pop_front());
        m_cnt++;
        if (m_cnt < RAND_NUM) q.push_back(m_lfsr[1:0]);
        else begin m_valid = 1'b0; m_st = S_SOLVE; end
      end
      S_SOLVE: begin
        if (solved) begin m_st = S_DONE; m_buzz = 0; end
        else if (press && mix_state) start = 1'b1;
        else if (!mix_state) m_st = S_IDLE;
      end
      S_DONE: if (m_buzz == BUZZ - 1) m_st = S_IDLE; else m_buzz++;
      default: m_st = S_IDLE;
    endcase
    if (start) begin
      m_st = S_SCR; m_valid = 1'b1; m_cnt = 0;
      q.delete();
      q.push_back(m_lfsr[1:0]);
    end
    m_lfsr = lfsr_nx(m_lfsr);
    m_btnq = scramble_button;
    @(posedge clk);
    @(negedge clk);
    chk("move_valid", move_valid, m_valid);
    chk("move_count", move_count, m_cnt);
    chk("busy", busy, m_st == S_SCR);
    chk("solve_mode", solve_mode, m_st == S_SOLVE);
    chk("no_buzz", no_buzz, m_st != S_DONE);
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear
  // before any edge arrives.
  task automatic do_reset();
    #2 reset = 1'b1;
    mix_state = 1'b0; scramble_button = 1'b0; solved = 1'b0; move_ack = 1'b0;
    #1;
    chk("rst_move_valid", move_valid, 1'b0);
    chk("rst_move_count", move_count, 8'd0);
    chk("rst_move_code", move_code, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_solve_mode", solve_mode, 1'b0);
    chk("rst_no_buzz", no_buzz, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Fixed timing from reset release to press, so the LFSR phase repeats.
  task automatic start_scr(output logic [1:0] first);
    mix_state = 1'b1;
    scramble_button = 1'b0;
    repeat (4) tick();
    scramble_button = 1'b1;
    tick();
    scramble_button = 1'b0;
    chk("start_valid", move_valid, 1'b1);
    first = move_code;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] first1, first6a, first6b;
    int n, lim, acks, starts, c;
    logic busy_q;

    reset = 1'b1; mix_state = 1'b0; scramble_button = 1'b0; solved = 1'b0; move_ack = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: ack tied high, 31 consecutive valid cycles, then SOLVE
    start_scr(first1);
    move_ack = 1'b1;
    n = 0; lim = 0;
    while (move_valid && lim < 100) begin n++; lim++; tick(); end
    chk("t1_valid_cycles", n, RAND_NUM);
    chk("t1_count", move_count, RAND_NUM);
    chk("t1_solve_mode", solve_mode, 1'b1);
    chk("t1_busy", busy, 1'b0);

    // 2: rescramble from SOLVE, ack 1 high / 3 low
    move_ack = 1'b0;
    scramble_button = 1'b1; tick(); scramble_button = 1'b0;
    chk("t2_busy", busy, 1'b1);
    acks = 0; c = 0; lim = 0;
    while (move_valid && lim < 500) begin
      move_ack = (c % 4 == 3);
      if (move_ack) acks++;
      c++; lim++;
      tick();
    end
    move_ack = 1'b0;
    chk("t2_acks", acks, RAND_NUM);
    chk("t2_solve_mode", solve_mode, 1'b1);

    // 4: solved and press together -> DONE wins, buzzer for BUZZ cycles
    solved = 1'b1; scramble_button = 1'b1; tick();
    solved = 1'b0; scramble_button = 1'b0;
    n = 0; lim = 0;
    while (!no_buzz && lim < 2000) begin n++; lim++; tick(); end
    chk("t4_buzz_cycles", n, BUZZ);
    chk("t4_idle_busy", busy, 1'b0);
    chk("t4_idle_solve", solve_mode, 1'b0);

    // 3: button held 50 cycles in ARMED -> exactly one scramble
    move_ack = 1'b1;
    tick(); tick();
    scramble_button = 1'b1;
    starts = 0; busy_q = busy;
    for (int i = 0; i < 70; i++) begin
      if (i == 50) scramble_button = 1'b0;
      tick();
      if (busy && !busy_q) starts++;
      busy_q = busy;
    end
    scramble_button = 1'b0;
    chk("t3_starts", starts, 1);
    chk("t3_solve_mode", solve_mode, 1'b1);

    // 5: mix_state dropped mid-scramble; scramble still completes
    scramble_button = 1'b1; tick(); scramble_button = 1'b0;
    tick(); tick();
    mix_state = 1'b0;
    lim = 0;
    while (busy && lim < 100) begin lim++; tick(); end
    chk("t5_count", move_count, RAND_NUM);
    chk("t5_solve_mode", solve_mode, 1'b1);
    tick();
    chk("t5_idle_solve", solve_mode, 1'b0);
    chk("t5_idle_busy", busy, 1'b0);

    // 6: reset mid-handshake at count 12, LFSR restarts from the seed
    do_reset();
    start_scr(first6a);
    chk("t6_first_a", first6a, first1);
    move_ack = 1'b1;
    lim = 0;
    while (move_count < 8'd12 && lim < 100) begin lim++; tick(); end
    move_ack = 1'b0;
    tick();
    chk("t6_pending_valid", move_valid, 1'b1);
    chk("t6_pending_count", move_count, 8'd12);
    do_reset();
    start_scr(first6b);
    chk("t6_first_b", first6b, first1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
